// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one Data_Memory between the CPU load/store path
// (port 0) and a debug/loader master (port 1). Each transaction runs
// IDLE -> ACCESS -> RESP: the winner is latched in IDLE, the memory is
// strobed for exactly one cycle in ACCESS, and a one-cycle ack (with an
// error flag for misaligned addresses) is returned in RESP.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // Port 0: CPU load/store path
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic              err0_o,
  // Port 1: debug / loader master
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic              err1_o,
  // Shared read data, valid while an ack is high for a read
  output logic [DATA_W-1:0] rdata_o,
  // Data_Memory side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  // Status
  output logic              busy_o,
  output logic              owner_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;

  // Latched transaction
  logic                lat_we;
  logic                lat_err;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic                owner;
  logic                last_grant;

  // Registered outputs
  logic [DATA_W-1:0]   rdata_q;
  logic                ack0_q;
  logic                ack1_q;
  logic                err0_q;
  logic                err1_q;
  logic                mem_read_q;
  logic                mem_write_q;
  logic                busy_q;

  // Winner selection and the winner's request fields
  logic                grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic                sel_misaligned;

  // Round-robin pick: a lone requester wins; on a tie the port that was
  // not served last wins.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    grant = 1'b0;
    if (req0_i && req1_i) begin
      grant = ~last_grant;
    end else if (req1_i) begin
      grant = 1'b1;
    end
  end

  // Mux the winning port's request fields onto the latch inputs.
  always_comb begin
    sel_we    = we0_i;
    sel_addr  = addr0_i;
    sel_wdata = wdata0_i;
    if (grant) begin
      sel_we    = we1_i;
      sel_addr  = addr1_i;
      sel_wdata = wdata1_i;
    end
    sel_misaligned = |sel_addr[1:0];
  end

  // Transaction sequencer: one registered FSM that owns every output, so
  // nothing at the boundary is decoded combinationally from inputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // Synchronous reset also serves as the mid-transaction abort: any
      // pending ack is dropped and the arbiter restarts from IDLE.
      state       <= IDLE;
      lat_we      <= 1'b0;
      lat_err     <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rdata_q     <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // Pulses default low; only the state that owns them raises them.
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;

      unique case (state)
        IDLE: begin
          if (req0_i || req1_i) begin
            owner       <= grant;
            lat_we      <= sel_we;
            lat_addr    <= sel_addr;
            lat_wdata   <= sel_wdata;
            lat_err     <= sel_misaligned;
            // Strobes are registered here so they are high for exactly
            // the ACCESS cycle; a misaligned request never touches memory.
            mem_write_q <= sel_we & ~sel_misaligned;
            mem_read_q  <= ~sel_we & ~sel_misaligned;
            busy_q      <= 1'b1;
            state       <= ACCESS;
          end
        end

        ACCESS: begin
          // Memory read is combinational, so its data is valid now.
          if (lat_we || lat_err) begin
            rdata_q <= '0;
          end else begin
            rdata_q <= mem_rdata_i;
          end
          ack0_q <= ~owner;
          ack1_q <= owner;
          err0_q <= ~owner & lat_err;
          err1_q <= owner & lat_err;
          state  <= RESP;
        end

        RESP: begin
          // Fairness pointer moves only once a transaction completes, so an
          // aborted transaction does not count as served.
          last_grant <= owner;
          busy_q     <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign err0_o      = err0_q;
  assign err1_o      = err1_q;
  assign rdata_o     = rdata_q;
  assign mem_addr_o  = lat_addr;
  assign mem_wdata_o = lat_wdata;
  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign busy_o      = busy_q;
  assign owner_o     = owner;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter. A small word-addressed
// memory stands in for Data_Memory; all expected values are hand-derived.
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic        ack0, err0, ack1, err1;
  logic [31:0] rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
  logic        busy, owner;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem [0:255];

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req0_i      (req0),
    .we0_i       (we0),
    .addr0_i     (addr0),
    .wdata0_i    (wdata0),
    .ack0_o      (ack0),
    .err0_o      (err0),
    .req1_i      (req1),
    .we1_i       (we1),
    .addr1_i     (addr1),
    .wdata1_i    (wdata1),
    .ack1_o      (ack1),
    .err1_o      (err1),
    .rdata_o     (rdata),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_rdata_i (mem_rdata),
    .busy_o      (busy),
    .owner_o     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural Data_Memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Structural invariants checked every cycle.
  always @(negedge clk) begin
    check("excl_ack", {63'd0, ack0 & ack1}, 64'd0);
    check("excl_strobe", {63'd0, mem_read & mem_write}, 64'd0);
  end

  // One complete transaction from IDLE: request, ACCESS, RESP, back to IDLE.
  task automatic do_txn(input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rdata);
    if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
    else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
    tick();  // cycle N+1: ACCESS
    check("acc_busy",  {63'd0, busy}, 64'd1);
    check("acc_owner", {63'd0, owner}, {63'd0, port});
    check("acc_write", {63'd0, mem_write}, {63'd0, we & ~exp_err});
    check("acc_read",  {63'd0, mem_read}, {63'd0, ~we & ~exp_err});
    check("acc_addr",  {32'd0, mem_addr}, {32'd0, addr});
    if (we && !exp_err) check("acc_wdata", {32'd0, mem_wdata}, {32'd0, wd});
    check("acc_noack", {62'd0, ack1, ack0}, 64'd0);
    tick();  // cycle N+2: RESP
    check("resp_ack0", {63'd0, ack0}, {63'd0, ~port});
    check("resp_ack1", {63'd0, ack1}, {63'd0, port});
    check("resp_err",  {63'd0, port ? err1 : err0}, {63'd0, exp_err});
    check("resp_rdata", {32'd0, rdata}, {32'd0, exp_rdata});
    check("resp_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    req0 = 0; req1 = 0;
    tick();  // cycle N+3: IDLE
    check("idle_ack", {62'd0, ack1, ack0}, 64'd0);
    check("idle_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_acks"}, {60'd0, ack0, ack1, err0, err1}, 64'd0);
    check({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
    check({tag, "_strobes"}, {62'd0, mem_read, mem_write}, 64'd0);
    check({tag, "_maddr"}, {32'd0, mem_addr}, 64'd0);
    check({tag, "_mwdata"}, {32'd0, mem_wdata}, 64'd0);
    check({tag, "_busy_owner"}, {62'd0, busy, owner}, 64'd0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #100us;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] b2b_addr [3];
    logic [31:0] b2b_data [3];
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[5] = 32'h0BADF00D;  // byte address 0x14

    rst = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    tick(); tick();
    rst = 0;
    check_reset_outputs("rst");

    // Single write from port 0, then read back from port 1.
    do_txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    check("mem_written", {32'd0, mem[4]}, {32'd0, 32'hDEADBEEF});
    do_txn(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Tie, both held for six transactions: acks alternate 0,1,0,1,0,1.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    for (int i = 1; i <= 18; i++) begin
      tick();
      check("tie_ack0", {63'd0, ack0}, {63'd0, (i % 6) == 2});
      check("tie_ack1", {63'd0, ack1}, {63'd0, (i % 6) == 5});
      if ((i % 3) == 1) check("tie_owner", {63'd0, owner}, {63'd0, ((i / 3) % 2) == 1});
      if ((i % 6) == 2) check("tie_rdata0", {32'd0, rdata}, {32'd0, 32'hDEADBEEF});
      if ((i % 6) == 5) check("tie_rdata1", {32'd0, rdata}, {32'd0, 32'h0BADF00D});
      if (i == 17) begin req0 = 0; req1 = 0; end
    end
    tick();
    check("tie_idle_busy", {63'd0, busy}, 64'd0);

    // Misaligned write is rejected without touching memory.
    do_txn(1'b0, 1'b1, 32'h12, 32'h12345678, 1'b1, 32'h0);
    check("mis_mem_intact", {32'd0, mem[4]}, {32'd0, 32'hDEADBEEF});
    do_txn(1'b0, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    // Reset during ACCESS of a port 1 read: no ack, outputs back to reset.
    req1 = 1; we1 = 0; addr1 = 32'h10;
    tick();
    check("abort_acc_read", {63'd0, mem_read}, 64'd1);
    rst = 1; req1 = 0;
    tick();
    check_reset_outputs("abort");
    rst = 0;
    tick();
    check("abort_no_late_ack", {62'd0, ack1, ack0}, 64'd0);

    // First tie after reset goes to port 0 even though port 0 was served last.
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h14;
    tick();
    check("post_rst_owner", {63'd0, owner}, 64'd0);
    tick();
    check("post_rst_ack0", {62'd0, ack1, ack0}, 64'd1);
    req0 = 0; req1 = 0;
    tick();

    // Port 0 back-to-back reads: acks at N+2, N+5, N+8; busy low only in IDLE.
    b2b_addr[0] = 32'h10; b2b_addr[1] = 32'h14; b2b_addr[2] = 32'h10;
    b2b_data[0] = 32'hDEADBEEF; b2b_data[1] = 32'h0BADF00D; b2b_data[2] = 32'hDEADBEEF;
    req0 = 1; we0 = 0; addr0 = b2b_addr[0];
    for (int i = 1; i <= 9; i++) begin
      tick();
      check("b2b_ack0", {63'd0, ack0}, {63'd0, (i % 3) == 2});
      check("b2b_busy", {63'd0, busy}, {63'd0, (i % 3) != 0});
      if ((i % 3) == 1) check("b2b_addr", {32'd0, mem_addr}, {32'd0, b2b_addr[i / 3]});
      if ((i % 3) == 2) begin
        check("b2b_rdata", {32'd0, rdata}, {32'd0, b2b_data[i / 3]});
        if (i == 8) req0 = 0;
        else addr0 = b2b_addr[i / 3 + 1];
      end
    end
    check("b2b_ack1_never", {63'd0, ack1}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer that shares the single Data_Memory instance between the CPU load/store path (port 0) and a debug/loader master (port 1). It accepts request/acknowledge transactions from both masters, selects a winner round-robin, drives the memory's address, data and read/write strobes for exactly one cycle, and returns read data with a one-cycle acknowledge. It sits between the requesters and the data memory, replacing the direct ALU-to-memory connection.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  reset, synchronous, active-high
- req0_i / req1_i  in  1  transaction request, held until matching ack
- we0_i / we1_i  in  1  1 = write, 0 = read; stable while req high
- addr0_i / addr1_i  in  ADDR_W  byte address; stable while req high
- wdata0_i / wdata1_i  in  DATA_W  write data; stable while req high
- ack0_o / ack1_o  out  1  one-cycle completion pulse for that port
- err0_o / err1_o  out  1  valid with ack: transaction rejected (misaligned)
- rdata_o  out  DATA_W  read data, valid only while an ack is high for a read
- mem_addr_o  out  ADDR_W  to Data_Memory addr_i
- mem_wdata_o  out  DATA_W  to Data_Memory data_i
- mem_read_o  out  1  to Data_Memory MemRead_i
- mem_write_o  out  1  to Data_Memory MemWrite_i
- mem_rdata_i  in  DATA_W  from Data_Memory data_o (combinational read)
- busy_o  out  1  high in ACCESS and RESP
- owner_o  out  1  port index of the current/last latched transaction

## Operation
- FSM states: IDLE, ACCESS, RESP. All outputs registered or decoded from registered state only.
- IDLE: if neither req high, stay. Otherwise pick winner, latch winner's we/addr/wdata and index into owner, go ACCESS.
- Arbitration: if only one req high, that port wins. If both high, the port not equal to last_grant wins. last_grant updates to owner on the RESP->IDLE transition. After reset last_grant = 1, so port 0 wins the first tie.
- Alignment check at latch: addr[1:0] != 0 sets an internal err flag. An erroring transaction passes through ACCESS with both mem strobes low; no memory side effect.
- ACCESS (one cycle): mem_addr_o = latched addr, mem_wdata_o = latched wdata, mem_write_o = we & ~err, mem_read_o = ~we & ~err. Capture mem_rdata_i into rdata register at end of cycle. Writes and errors load rdata with 0. Go RESP.
- RESP (one cycle): ack for owner port high, the other port's ack low; err for owner = err flag; rdata_o = captured value. Go IDLE.
- Outside ACCESS: mem_read_o = mem_write_o = 0. mem_addr_o/mem_wdata_o hold the latched values, which do not matter while the strobes are low.
- Reset values: state IDLE, ack0/ack1/err0/err1 = 0, rdata_o = 0, mem strobes = 0, mem_addr_o = 0, mem_wdata_o = 0, busy_o = 0, owner_o = 0, last_grant = 1.
- Reset mid-transaction (ACCESS or RESP): abort to IDLE next edge. No ack is issued. A write already strobed in ACCESS has happened; an aborted RESP loses its ack. Requesters must re-issue after reset.

## Timing
- Req first sampled high in IDLE at edge N: ACCESS during cycle N+1, ack high during cycle N+2, back to IDLE at cycle N+3.
- Latency is 2 cycles from the sampling edge to ack. Minimum transaction period is 3 cycles.
- Requester drops req (or changes to the next transaction) on the edge ending its ack cycle. Req seen high in the IDLE cycle after an ack is a new transaction.
- Requester must keep we/addr/wdata stable only until the IDLE latch edge, but holding them until ack is required by protocol.
- Both ports continuously requesting: grants alternate 0,1,0,1..., one ack every 3 cycles, none starved.
- A req asserted during ACCESS/RESP waits; it is evaluated in the next IDLE cycle.
- ack0_o and ack1_o are never high simultaneously. mem_read_o and mem_write_o are never high simultaneously.

## Test plan
- Reset then single write: port 0 writes 0xDEADBEEF to 0x10 -> mem_write_o high exactly 1 cycle (cycle N+1) with addr 0x10; ack0 at N+2, err0=0; ack1 never high.
- Read-back: port 1 reads 0x10 -> mem_read_o one cycle; ack1 at N+2 with rdata_o=0xDEADBEEF, err1=0.
- Tie after reset: both request reads in the same cycle -> port 0 acked first, then port 1 acked 3 cycles later; with both held continuously for 6 transactions, ack order is 0,1,0,1,0,1.
- Misaligned: port 0 writes 0x12 -> ack0 with err0=1, mem_write_o never asserted, and a read of 0x10 still returns the old value.
- Reset mid-op: assert rst_i during ACCESS of a port 1 read -> no ack1, state IDLE, all outputs at reset values next cycle; the first tie afterwards grants port 0.
- Back-to-back single master: port 0 holds req for 3 reads -> acks at cycles N+2, N+5, N+8; busy_o low exactly in the IDLE cycles between transactions.
